// File: rtl/commutation_controller.sv
// Six-step BLDC commutation controller.
//
// Hall sensors are synchronised and glitch-filtered. The accepted code picks
// the PWM / low / floating phase of each step. Every drive-pattern change is
// separated by a dead-time window in which all phases are off. Invalid hall
// codes and stalls are reported as faults.
//
// Ports
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   enable       1 = run, 0 = coast (also clears a latched fault)
//   direction    0 = forward table, 1 = reverse (PWM and low roles swapped)
//   brake        1 = all low sides on
//   duty_cycle   commanded duty
//   hall         raw hall inputs {C,B,A}, asynchronous
//   duty_a/b/c   per-phase duty to the phase drivers
//   high_z       {C,B,A}, 1 forces that phase driver off
//   fault        1 while in the fault state
//   fault_code   0 none, 1 invalid hall, 2 stall
module commutation_controller #(
  parameter int DUTY_CYCLE_WIDTH = 10,
  parameter int DEAD_CYCLES      = 8,
  parameter int HALL_FILTER      = 3,
  parameter int STALL_CYCLES     = 1048576
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        direction,
  input  logic                        brake,
  input  logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
  input  logic [2:0]                  hall,
  output logic [DUTY_CYCLE_WIDTH-1:0] duty_a,
  output logic [DUTY_CYCLE_WIDTH-1:0] duty_b,
  output logic [DUTY_CYCLE_WIDTH-1:0] duty_c,
  output logic [2:0]                  high_z,
  output logic                        fault,
  output logic [1:0]                  fault_code
);

  localparam int DW = $clog2(DEAD_CYCLES) + 1;
  localparam int SW = $clog2(STALL_CYCLES) + 1;
  localparam int FW = $clog2(HALL_FILTER + 1);

  localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_CYCLES - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);
  localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_CYCLES);
  localparam logic [FW-1:0] FILT_N     = FW'(HALL_FILTER);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAD,
    ST_DRIVE,
    ST_BRAKE,
    ST_FAULT
  } state_t;

  // ---------------------------------------------------------------------
  // Hall synchroniser and filter
  // ---------------------------------------------------------------------
  logic [2:0]    sync1, sync2;
  logic [1:0]    fill;       // marks when sync2 holds a real post-reset sample
  logic [2:0]    cand;
  logic [FW-1:0] fcnt;       // 0 means no candidate yet
  logic [FW-1:0] fcnt_nx;
  logic [2:0]    acc;
  logic          acc_valid;
  logic          accept;
  logic          acc_new;

  always_comb begin
    fcnt_nx = FW'(1);
    if ((fcnt != '0) && (sync2 == cand))
      fcnt_nx = (fcnt == FILT_N) ? fcnt : fcnt + 1'b1;
    accept  = fill[1] && (fcnt_nx == FILT_N);
    acc_new = accept && (!acc_valid || (sync2 != acc));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      fill      <= '0;
      cand      <= '0;
      fcnt      <= '0;
      acc       <= '0;
      acc_valid <= 1'b0;
    end else begin
      sync1 <= hall;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      if (fill[1]) begin
        cand <= sync2;
        fcnt <= fcnt_nx;
      end
      if (accept) begin
        acc       <= sync2;
        acc_valid <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  state_t                state, state_nx;
  state_t                target, target_nx;
  logic [1:0]            code_nx;
  logic [DW-1:0]         dead_cnt;
  logic [SW-1:0]         stall_cnt;
  logic                  dead_clr, stall_clr, latch;
  logic                  hall_bad, stall_hit;
  logic [2:0]            drv_hall;
  logic                  drv_dir;
  logic [DUTY_CYCLE_WIDTH-1:0] duty_q;

  assign hall_bad  = acc_valid && ((acc == 3'b000) || (acc == 3'b111));
  assign stall_hit = (state == ST_DRIVE) && (duty_cycle != '0) &&
                     (stall_cnt >= STALL_LAST);

  always_comb begin
    state_nx  = state;
    target_nx = target;
    code_nx   = fault_code;
    dead_clr  = 1'b0;
    stall_clr = 1'b0;
    latch     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nx  = ST_DEAD;
          target_nx = brake ? ST_BRAKE : ST_DRIVE;
          dead_clr  = 1'b1;
        end
      end
      ST_DEAD: begin
        if ((target == ST_DRIVE) && hall_bad) begin
          state_nx = ST_FAULT;
          code_nx  = 2'd1;
        end else if ((dead_cnt == DEAD_LAST) &&
                     ((target == ST_BRAKE) || acc_valid)) begin
          // entry to DRIVE waits until a hall code has been accepted
          state_nx = target;
          if (target == ST_DRIVE) begin
            latch     = 1'b1;
            stall_clr = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        if (hall_bad) begin
          state_nx = ST_FAULT;
          code_nx  = 2'd1;
        end else if (stall_hit) begin
          state_nx = ST_FAULT;
          code_nx  = 2'd2;
        end else if (brake) begin
          state_nx  = ST_DEAD;
          target_nx = ST_BRAKE;
          dead_clr  = 1'b1;
        end else if ((acc != drv_hall) || (direction != drv_dir)) begin
          state_nx  = ST_DEAD;
          target_nx = ST_DRIVE;
          dead_clr  = 1'b1;
        end
      end
      ST_BRAKE: begin
        if (!brake) begin
          state_nx  = ST_DEAD;
          target_nx = ST_DRIVE;
          dead_clr  = 1'b1;
        end
      end
      ST_FAULT: begin
        state_nx = ST_FAULT;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    if (!enable) begin
      state_nx = ST_IDLE;
      code_nx  = 2'd0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      target     <= ST_DRIVE;
      fault_code <= 2'd0;
      dead_cnt   <= '0;
      stall_cnt  <= '0;
      drv_hall   <= '0;
      drv_dir    <= 1'b0;
      duty_q     <= '0;
    end else begin
      state      <= state_nx;
      target     <= target_nx;
      fault_code <= code_nx;
      duty_q     <= duty_cycle;
      if (latch) begin
        drv_hall <= acc;
        drv_dir  <= direction;
      end
      if (dead_clr)
        dead_cnt <= '0;
      else if ((state == ST_DEAD) && (dead_cnt != DEAD_LAST))
        dead_cnt <= dead_cnt + 1'b1;
      if (stall_clr || acc_new)
        stall_cnt <= '0;
      else if ((state == ST_DRIVE) && (duty_cycle != '0) && (stall_cnt != STALL_MAX))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Output decode: one-hot PWM and low phases, remaining phase floats
  // ---------------------------------------------------------------------
  logic [2:0] fwd_pwm, fwd_low, pwm_oh, low_oh;

  always_comb begin
    fwd_pwm = 3'b000;
    fwd_low = 3'b000;
    case (drv_hall)
      3'b101: begin fwd_pwm = 3'b001; fwd_low = 3'b010; end
      3'b100: begin fwd_pwm = 3'b001; fwd_low = 3'b100; end
      3'b110: begin fwd_pwm = 3'b010; fwd_low = 3'b100; end
      3'b010: begin fwd_pwm = 3'b010; fwd_low = 3'b001; end
      3'b011: begin fwd_pwm = 3'b100; fwd_low = 3'b001; end
      3'b001: begin fwd_pwm = 3'b100; fwd_low = 3'b010; end
      default: begin fwd_pwm = 3'b000; fwd_low = 3'b000; end
    endcase
    pwm_oh = drv_dir ? fwd_low : fwd_pwm;
    low_oh = drv_dir ? fwd_pwm : fwd_low;

    duty_a = '0;
    duty_b = '0;
    duty_c = '0;
    high_z = 3'b111;
    if (state == ST_DRIVE) begin
      high_z = ~(pwm_oh | low_oh);
      if (pwm_oh[0]) duty_a = duty_q;
      if (pwm_oh[1]) duty_b = duty_q;
      if (pwm_oh[2]) duty_c = duty_q;
    end else if (state == ST_BRAKE) begin
      high_z = 3'b000;
    end
  end

  assign fault = (state == ST_FAULT);

endmodule

// File: tb/tb_commutation_controller.sv
// Testbench for commutation_controller: directed sequences with literal
// expectations, followed by randomized stimulus, all checked every cycle
// against a behavioural model.
module tb_commutation_controller;

  localparam int W     = 10;
  localparam int DEAD  = 8;
  localparam int HF    = 3;
  localparam int STALL = 100;

  localparam int M_IDLE  = 0;
  localparam int M_DEAD  = 1;
  localparam int M_DRIVE = 2;
  localparam int M_BRAKE = 3;
  localparam int M_FAULT = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         direction = 1'b0;
  logic         brake = 1'b0;
  logic [W-1:0] duty_cycle = '0;
  logic [2:0]   hall = 3'b101;
  logic [W-1:0] duty_a, duty_b, duty_c;
  logic [2:0]   high_z;
  logic         fault;
  logic [1:0]   fault_code;

  int checks = 0;
  int passes = 0;

  commutation_controller #(
    .DUTY_CYCLE_WIDTH(W),
    .DEAD_CYCLES(DEAD),
    .HALL_FILTER(HF),
    .STALL_CYCLES(STALL)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .direction(direction),
    .brake(brake),
    .duty_cycle(duty_cycle),
    .hall(hall),
    .duty_a(duty_a),
    .duty_b(duty_b),
    .duty_c(duty_c),
    .high_z(high_z),
    .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  int         m_mode = M_IDLE;
  int         m_target = M_DRIVE;
  int         m_dead = 0;    // dead clocks elapsed, including the current one
  int         m_stall = 0;   // nonzero-duty DRIVE clocks since last reset
  int         m_code = 0;
  logic [2:0] m_acc = 3'b000;
  bit         m_acc_ok = 1'b0;
  logic [2:0] m_pat = 3'b000;
  bit         m_pdir = 1'b0;
  int         m_dq = 0;
  logic [2:0] raw_q[$];
  logic [2:0] smp_q[$];

  int e_duty[3];
  int e_hz = 7;
  int e_fault = 0;
  int e_code = 0;

  function automatic int pwm_phase(input logic [2:0] c);
    case (c)
      3'b101, 3'b100: return 0;
      3'b110, 3'b010: return 1;
      3'b011, 3'b001: return 2;
      default:        return -1;
    endcase
  endfunction

  function automatic int low_phase(input logic [2:0] c);
    case (c)
      3'b010, 3'b011: return 0;
      3'b101, 3'b001: return 1;
      3'b100, 3'b110: return 2;
      default:        return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_target = M_DRIVE; m_dead = 0; m_stall = 0; m_code = 0;
    m_acc = 3'b000; m_acc_ok = 1'b0; m_pat = 3'b000; m_pdir = 1'b0; m_dq = 0;
    raw_q.delete();
    smp_q.delete();
  endtask

  task automatic model_step();
    logic [2:0] old_acc;
    bit         old_ok;
    bit         bad;
    bit         acc_new;
    bit         same;
    old_acc = m_acc;
    old_ok  = m_acc_ok;
    bad     = old_ok && ((old_acc == 3'b000) || (old_acc == 3'b111));
    if (!enable) begin
      m_mode = M_IDLE;
      m_code = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_mode = M_DEAD; m_target = brake ? M_BRAKE : M_DRIVE; m_dead = 1;
        end
        M_DEAD: begin
          if (m_target == M_DRIVE && bad) begin
            m_mode = M_FAULT; m_code = 1;
          end else if (m_dead >= DEAD && (m_target == M_BRAKE || old_ok)) begin
            m_mode = m_target;
            if (m_target == M_DRIVE) begin
              m_pat = old_acc; m_pdir = direction; m_stall = 0;
            end
          end else if (m_dead < DEAD) begin
            m_dead++;
          end
        end
        M_DRIVE: begin
          if (bad) begin
            m_mode = M_FAULT; m_code = 1;
          end else if (duty_cycle != 0 && m_stall + 1 >= STALL) begin
            m_mode = M_FAULT; m_code = 2;
          end else if (brake) begin
            m_mode = M_DEAD; m_target = M_BRAKE; m_dead = 1;
          end else if (old_acc != m_pat || direction != m_pdir) begin
            m_mode = M_DEAD; m_target = M_DRIVE; m_dead = 1;
          end
          if (duty_cycle != 0) m_stall++;
        end
        M_BRAKE: begin
          if (!brake) begin
            m_mode = M_DEAD; m_target = M_DRIVE; m_dead = 1;
          end
        end
        default: ;
      endcase
    end
    m_dq = int'(duty_cycle);

    // hall seen by the filter is the raw value from two clocks earlier
    acc_new = 1'b0;
    raw_q.push_back(hall);
    if (raw_q.size() >= 3) begin
      smp_q.push_back(raw_q[raw_q.size() - 3]);
      if (smp_q.size() >= HF) begin
        same = 1'b1;
        for (int k = 0; k < HF; k++)
          if (smp_q[smp_q.size() - 1 - k] != smp_q[smp_q.size() - 1]) same = 1'b0;
        if (same) begin
          if (!m_acc_ok || smp_q[smp_q.size() - 1] != m_acc) acc_new = 1'b1;
          m_acc    = smp_q[smp_q.size() - 1];
          m_acc_ok = 1'b1;
        end
      end
    end
    if (raw_q.size() > 3) void'(raw_q.pop_front());
    if (smp_q.size() > HF) void'(smp_q.pop_front());
    if (acc_new) m_stall = 0;
  endtask

  task automatic model_outputs();
    int p, l, t;
    e_duty[0] = 0; e_duty[1] = 0; e_duty[2] = 0;
    e_hz = 7;
    if (m_mode == M_DRIVE) begin
      p = pwm_phase(m_pat);
      l = low_phase(m_pat);
      if (m_pdir) begin t = p; p = l; l = t; end
      if (p >= 0) begin
        e_duty[p] = m_dq;
        e_hz = 7 - (1 << p) - (1 << l);
      end
    end else if (m_mode == M_BRAKE) begin
      e_hz = 0;
    end
    e_fault = (m_mode == M_FAULT) ? 1 : 0;
    e_code  = m_code;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
    model_outputs();
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    checks++;
    if (duty_a == W'(e_duty[0]) && duty_b == W'(e_duty[1]) && duty_c == W'(e_duty[2]) &&
        high_z == 3'(e_hz) && fault == 1'(e_fault) && fault_code == 2'(e_code))
      passes++;
    else
      $display("FAIL outputs t=%0t: dut a/b/c=%0d/%0d/%0d hz=%b fault=%b code=%0d, required a/b/c=%0d/%0d/%0d hz=%b fault=%0d code=%0d",
               $time, duty_a, duty_b, duty_c, high_z, fault, fault_code,
               e_duty[0], e_duty[1], e_duty[2], 3'(e_hz), e_fault, e_code);
  end

  // Literal expectation applied to both the DUT and the model
  task automatic lit(input string name, input int dut_v, input int model_v, input int exp);
    checks++;
    if (dut_v == exp) passes++;
    else $display("FAIL %s: dut=%0d required=%0d", name, dut_v, exp);
    checks++;
    if (model_v == exp) passes++;
    else $display("FAIL %s (model): model=%0d required=%0d", name, model_v, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  logic [2:0] seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  initial begin
    int pos;
    int glitch;
    int rate;
    logic [2:0] gval;
    duty_cycle = W'(300);
    tick(3);
    lit("reset_hz", int'(high_z), e_hz, 7);
    lit("reset_fault", int'(fault), e_fault, 0);
    lit("reset_duty_a", int'(duty_a), e_duty[0], 0);

    // Start-up: dead time then first step
    reset_n = 1'b1;
    enable  = 1'b1;
    tick(8);
    lit("startup_dead_hz", int'(high_z), e_hz, 7);
    tick(1);
    lit("startup_hz", int'(high_z), e_hz, 4);
    lit("startup_duty_a", int'(duty_a), e_duty[0], 300);
    lit("startup_duty_b", int'(duty_b), e_duty[1], 0);

    // Hall step 101 -> 100
    hall = 3'b100;
    tick(5);
    lit("step_filter_hz", int'(high_z), e_hz, 4);
    tick(1);
    lit("step_dead_first_hz", int'(high_z), e_hz, 7);
    tick(7);
    lit("step_dead_last_hz", int'(high_z), e_hz, 7);
    tick(1);
    lit("step_hz", int'(high_z), e_hz, 2);
    lit("step_duty_a", int'(duty_a), e_duty[0], 300);
    lit("step_duty_c", int'(duty_c), e_duty[2], 0);

    // Two-clock glitch must be rejected
    hall = 3'b101;
    tick(2);
    hall = 3'b100;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      lit("glitch_hz", int'(high_z), e_hz, 2);
    end

    // Brake from DRIVE, then release
    brake = 1'b1;
    tick(1);
    lit("brake_dead_hz", int'(high_z), e_hz, 7);
    tick(7);
    lit("brake_dead_last_hz", int'(high_z), e_hz, 7);
    tick(1);
    lit("brake_hz", int'(high_z), e_hz, 0);
    lit("brake_duty_a", int'(duty_a), e_duty[0], 0);
    brake = 1'b0;
    tick(1);
    lit("unbrake_dead_hz", int'(high_z), e_hz, 7);
    tick(8);
    lit("unbrake_hz", int'(high_z), e_hz, 2);

    // Asynchronous reset while driving
    #2 reset_n = 1'b0;
    #1;
    lit("async_reset_hz", int'(high_z), e_hz, 7);
    lit("async_reset_duty_a", int'(duty_a), e_duty[0], 0);
    @(negedge clock);
    hall    = 3'b101;
    reset_n = 1'b1;
    tick(9);
    lit("restart_hz", int'(high_z), e_hz, 4);

    // Invalid hall in DRIVE
    hall = 3'b111;
    tick(5);
    lit("bad_hall_filter_hz", int'(high_z), e_hz, 4);
    tick(1);
    lit("bad_hall_fault", int'(fault), e_fault, 1);
    lit("bad_hall_code", int'(fault_code), e_code, 1);
    lit("bad_hall_hz", int'(high_z), e_hz, 7);
    tick(3);
    lit("bad_hall_held", int'(fault_code), e_code, 1);
    enable = 1'b0;
    tick(1);
    lit("clear_fault", int'(fault), e_fault, 0);
    lit("clear_code", int'(fault_code), e_code, 0);

    // Stall detection with nonzero duty
    hall = 3'b101;
    tick(6);
    enable = 1'b1;
    tick(9);
    lit("stall_drive_hz", int'(high_z), e_hz, 4);
    tick(99);
    lit("stall_before", int'(fault), e_fault, 0);
    tick(1);
    lit("stall_fault", int'(fault), e_fault, 1);
    lit("stall_code", int'(fault_code), e_code, 2);
    enable = 1'b0;
    tick(1);
    duty_cycle = '0;
    enable = 1'b1;
    tick(9);
    tick(150);
    lit("zero_duty_no_stall", int'(fault), e_fault, 0);
    lit("zero_duty_hz", int'(high_z), e_hz, 4);

    // Randomized operation
    pos = 0;
    glitch = 0;
    gval = 3'b000;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      rate = (i < 3000) ? 40 : 400;
      if ($urandom_range(0, rate - 1) == 0)
        pos = (pos + (($urandom_range(0, 1) == 1) ? 1 : 5)) % 6;
      if (glitch > 0) glitch--;
      else if ($urandom_range(0, 59) == 0) begin
        glitch = $urandom_range(1, 4);
        gval   = 3'($urandom_range(0, 7));
      end
      hall   = (glitch > 0) ? gval : seq[pos];
      enable = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 199) == 0) brake = ~brake;
      if ($urandom_range(0, 249) == 0) direction = ~direction;
      if ($urandom_range(0, 59) == 0)
        duty_cycle = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 1023));
      if ($urandom_range(0, 1499) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b1;
      end
    end

    tick(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
